// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package mmio_uart_pkg;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   localparam logic [3:0] DATA_OFS = 4'd0;
   localparam logic [3:0] STAT_OFS = 4'd4;
   localparam logic [3:0] DIV_OFS  = 4'd8;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_CNT   = 8;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus connection between the single-cycle core (master) and the
// UART peripheral (slave); reads are combinational.
interface mmio_uart_tx_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0] WriteData;
   logic                  MemWrite;
   logic [DATA_WIDTH-1:0] ReadData;
   logic                  Hit;

   modport master (output Address, output WriteData, output MemWrite,
                   input ReadData, input Hit);
   modport slave  (input Address, input WriteData, input MemWrite,
                   output ReadData, output Hit);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Circular transmit FIFO; full/empty come from the registered count and a
// push while full is ignored even if a pop happens in the same cycle.
module tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a DATA/STATUS/DIV register window.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000,
   parameter int                    FIFO_DEPTH = 8,
   parameter logic [15:0]           DIV_RST    = 16'd16
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_uart_tx_if.slave        bus,
   output logic                 tx
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] ofs;
   logic [3:0]            reg_sel;
   logic                  hit, wr_en, push, pop;
   logic [7:0]            fifo_head;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic                  ovf_reg;
   logic [15:0]           div_reg;
   logic [DATA_WIDTH-1:0] status, rdata;
   logic                  unused_wdata;

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next, fdiv_reg, fdiv_next;
   logic [2:0]  idx_reg, idx_next;
   logic [7:0]  shift_reg, shift_next;
   logic        load_frame;
`ifdef UART_TX_PARITY_EN
   logic        par_reg, par_next;
`endif

   // Unsigned offset: anything below BASE wraps to a huge value and misses.
   assign ofs          = bus.Address - BASE_ADDR;
   assign hit          = (ofs < DATA_WIDTH'(12));
   assign reg_sel      = {ofs[3:2], 2'b00};
   assign wr_en        = bus.MemWrite && hit;
   assign push         = wr_en && (reg_sel == DATA_OFS);
   assign unused_wdata = &{1'b0, bus.WriteData[DATA_WIDTH-1:16]};

   tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (bus.WriteData[7:0]),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      status                     = '0;
      status[STAT_BUSY]          = (state_reg != IDLE);
      status[STAT_FULL]          = fifo_full;
      status[STAT_EMPTY]         = fifo_empty;
      status[STAT_OVF]           = ovf_reg;
      status[STAT_CNT +: CNT_W]  = fifo_count;
      rdata = '0;
      if (hit) begin
         case (reg_sel)
            STAT_OFS: rdata = status;
            DIV_OFS:  rdata = {{(DATA_WIDTH-16){1'b0}}, div_reg};
            default:  rdata = '0;
         endcase
      end
   end

   assign bus.ReadData = rdata;
   assign bus.Hit      = hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_reg <= 1'b0;
         div_reg <= DIV_RST;
      end else begin
         if (push && fifo_full)
            ovf_reg <= 1'b1;
         else if (wr_en && (reg_sel == STAT_OFS) && bus.WriteData[3])
            ovf_reg <= 1'b0;
         if (wr_en && (reg_sel == DIV_OFS))
            div_reg <= (bus.WriteData[15:0] == 16'd0) ? 16'd1 : bus.WriteData[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         fdiv_reg  <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
         par_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         fdiv_reg  <= fdiv_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
`ifdef UART_TX_PARITY_EN
         par_reg   <= par_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      fdiv_next  = fdiv_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
`ifdef UART_TX_PARITY_EN
      par_next   = par_reg;
`endif
      load_frame = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         IDLE: load_frame = !fifo_empty;
         START: begin
            if (cnt_reg == 16'd0) begin
               cnt_next   = fdiv_reg - 16'd1;
               state_next = DATA;
            end else cnt_next = cnt_reg - 16'd1;
         end
         DATA: begin
            if (cnt_reg == 16'd0) begin
               cnt_next = fdiv_reg - 16'd1;
               if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  shift_next = shift_reg >> 1;
                  idx_next   = idx_reg + 3'd1;
               end
            end else cnt_next = cnt_reg - 16'd1;
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (cnt_reg == 16'd0) begin
               cnt_next   = fdiv_reg - 16'd1;
               state_next = STOP;
            end else cnt_next = cnt_reg - 16'd1;
         end
`endif
         STOP: begin
            if (cnt_reg == 16'd0) begin
               state_next = IDLE;
               load_frame = !fifo_empty;
            end else cnt_next = cnt_reg - 16'd1;
         end
         default: state_next = IDLE;
      endcase
      // Frame divisor is latched here so DIV writes only affect later frames.
      if (load_frame) begin
         pop        = 1'b1;
         shift_next = fifo_head;
         fdiv_next  = div_reg;
         cnt_next   = div_reg - 16'd1;
         idx_next   = 3'd0;
         state_next = START;
`ifdef UART_TX_PARITY_EN
         par_next   = ^fifo_head;
`endif
      end
   end

   always_comb begin
      tx = 1'b1;
      case (state_reg)
         START:   tx = 1'b0;
         DATA:    tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx = par_reg;
`endif
         default: tx = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed/randomized bench for mmio_uart_tx: frames are checked bit by bit
// against a serial-frame model built from each byte and divisor.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h1001_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;
   int   checks = 0;
   int   errors = 0;

   mmio_uart_tx_if #(.DATA_WIDTH(32)) bus_if ();

   mmio_uart_tx #(
      .DATA_WIDTH (32),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .DIV_RST    (16'd16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] stat(input int busy, full, empty, ovf, cnt);
      return 32'(busy) | (32'(full) << 1) | (32'(empty) << 2) | (32'(ovf) << 3) | (32'(cnt) << 8);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus_if.Address   = a;
      bus_if.WriteData = d;
      bus_if.MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.MemWrite  = 1'b0;
      bus_if.Address   = 32'h0;
      bus_if.WriteData = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus_if.Address = a;
      #1;
      d = bus_if.ReadData;
   endtask

   // Serial frame: start 0, data LSB first, optional even parity, stop 1.
   task automatic expect_frame(input logic [7:0] b, input int div);
      logic bits[$];
      int   matched;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++) begin
         matched = 0;
         for (int c = 0; c < div; c++) begin
            @(negedge clk);
            if (tx === bits[k]) matched++;
         end
         check($sformatf("frame %h bit %0d cycles", b, k), 32'(matched), 32'(div));
      end
   endtask

   task automatic expect_idle();
      logic [31:0] d;
      @(negedge clk);
      check("tx idle after frames", 32'(tx), 32'd1);
      bus_read(BASE + 4, d);
      check("status idle after frames", d, stat(0, 0, 1, 0, 0));
   endtask

   task automatic send_and_check(input logic [7:0] b [8], input int n, input int div);
      logic [31:0] d;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               bus_write(BASE, {24'h0, b[i]});
               if (i == 0) begin
                  bus_read(BASE + 4, d);
                  check("status after first push", d, stat(0, 0, 0, 0, 1));
               end
            end
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check("tx high in pop cycle", 32'(tx), 32'd1);
            for (int j = 0; j < n; j++) expect_frame(b[j], div);
         end
      join
      expect_idle();
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  bytes [8];
      logic [7:0]  big [10];
      logic [7:0]  x, y;
      int          div, n, lows;

      bus_if.Address   = 32'h0;
      bus_if.WriteData = 32'h0;
      bus_if.MemWrite  = 1'b0;

      repeat (3) @(negedge clk);
      check("tx during reset", 32'(tx), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("tx after reset", 32'(tx), 32'd1);
      bus_read(BASE + 4, d);  check("status after reset", d, 32'h004);
      bus_read(BASE + 8, d);  check("div after reset", d, 32'd16);
      bus_read(BASE, d);      check("data reads zero", d, 32'd0);
      check("hit at data", 32'(bus_if.Hit), 32'd1);
      bus_read(BASE + 12, d); check("readdata at base+12", d, 32'd0);
      check("hit at base+12", 32'(bus_if.Hit), 32'd0);
      bus_read(BASE - 4, d);  check("hit below base", 32'(bus_if.Hit), 32'd0);
      @(negedge clk);

      bytes = '{default: 8'h00};
      bytes[0] = 8'h55;
      send_and_check(bytes, 1, 16);

      bus_write(BASE + 8, 32'd3);
      bus_read(BASE + 8, d); check("div readback 3", d, 32'd3);
      bytes[0] = 8'hA5; bytes[1] = 8'h3C;
      send_and_check(bytes, 2, 3);

      for (int r = 0; r < 3; r++) begin
         div = $urandom_range(1, 4);
         n   = $urandom_range(2, 5);
         for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
         if (r == 0) bytes[0] = 8'h07;
         bus_write(BASE + 8, 32'(div));
         send_and_check(bytes, n, div);
      end

      // With a 100-clock divisor, one byte sits in the shifter and 8 fill
      // the FIFO, so of 10 back-to-back writes only the 10th is lost.
      bus_write(BASE + 8, 32'd100);
      for (int i = 0; i < 10; i++) big[i] = 8'($urandom);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               bus_write(BASE, {24'h0, big[i]});
               if (i == 0) begin
                  bus_read(BASE + 4, d);
                  check("status after first of ten", d, stat(0, 0, 0, 0, 1));
               end
            end
            bus_read(BASE + 4, d);
            check("status overflowed", d, stat(1, 1, 0, 1, 8));
            bus_write(BASE + 4, 32'h8);
            bus_read(BASE + 4, d);
            check("status overflow cleared", d, stat(1, 1, 0, 0, 8));
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check("tx high before overflow run", 32'(tx), 32'd1);
            for (int j = 0; j < 9; j++) expect_frame(big[j], 100);
         end
      join
      expect_idle();
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("dropped byte never sent", 32'(lows), 32'd0);

      bus_write(BASE + 8, 32'd16);
      x = 8'($urandom);
      y = 8'($urandom);
      fork
         begin
            bus_write(BASE, {24'h0, x});
            bus_write(BASE, {24'h0, y});
            repeat (40) @(negedge clk);
            bus_write(BASE + 8, 32'd8);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check("tx high before div-change run", 32'(tx), 32'd1);
            expect_frame(x, 16);
            expect_frame(y, 8);
         end
      join
      expect_idle();
      bus_write(BASE + 8, 32'd0);
      bus_read(BASE + 8, d); check("div zero stored as one", d, 32'd1);

      bus_write(BASE + 8, 32'd16);
      bus_write(BASE, 32'h00);
      bus_write(BASE, 32'hFF);
      repeat (30) @(negedge clk);
      check("tx low in data before reset", 32'(tx), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("tx high immediately on reset", 32'(tx), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus_read(BASE + 4, d); check("status after mid-frame reset", d, 32'h004);
      bus_read(BASE + 8, d); check("div after mid-frame reset", d, 32'd16);
      lows = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("no frames after reset", 32'(lows), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
